// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant is held for a whole packet (until last) or until MAX_BURST beats have moved.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned BITWIDTH       = 64,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned REQ_BITWIDTH   = $clog2(NUM_REQ),
    parameter int unsigned BURST_BITWIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*BITWIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_o,
    output logic [BITWIDTH-1:0]           fifo_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [REQ_BITWIDTH-1:0]       grant_id_o,
    output logic [BURST_BITWIDTH-1:0]     beat_cnt_o,
    output logic                          burst_err_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [BURST_BITWIDTH-1:0] MaxBurstCnt = BURST_BITWIDTH'(MAX_BURST);
    localparam logic [REQ_BITWIDTH-1:0]   LastReq     = REQ_BITWIDTH'(NUM_REQ - 1);

    state_e                    state_q, state_d;
    logic [REQ_BITWIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_BITWIDTH-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [BURST_BITWIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                      burst_err_q, burst_err_d;

    logic                      arb_found;
    logic [REQ_BITWIDTH-1:0]   arb_id;
    logic                      granted;
    logic                      cur_valid;
    logic                      cur_last;
    logic                      transfer;
    logic [BURST_BITWIDTH-1:0] beat_cnt_inc;
    logic                      burst_hit;

    // Two descending passes: the lowest valid index at/after rr_ptr wins, otherwise the
    // lowest valid index below rr_ptr. Equivalent to a modulo scan without any wrap math.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (req_valid_i[j] && (REQ_BITWIDTH'(j) < rr_ptr_q)) begin
                arb_found = 1'b1;
                arb_id    = REQ_BITWIDTH'(j);
            end
        end
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (req_valid_i[j] && (REQ_BITWIDTH'(j) >= rr_ptr_q)) begin
                arb_found = 1'b1;
                arb_id    = REQ_BITWIDTH'(j);
            end
        end
    end

    assign granted      = (state_q == StGrant);
    assign cur_valid    = req_valid_i[grant_id_q];
    assign cur_last     = req_last_i[grant_id_q];
    assign transfer     = granted & cur_valid & ~fifo_full_i;
    assign beat_cnt_inc = beat_cnt_q + 1'b1;
    assign burst_hit    = (beat_cnt_inc == MaxBurstCnt);

    always_comb begin
        req_ready_o = '0;
        fifo_wr_o   = transfer;
        fifo_data_o = '0;
        if (granted) begin
            req_ready_o[grant_id_q] = ~fifo_full_i;
            fifo_data_o             = req_data_i[grant_id_q*BITWIDTH +: BITWIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        burst_err_d = burst_err_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d    = StGrant;
                    grant_id_d = arb_id;
                    grant_d    = NUM_REQ'(1) << arb_id;
                end
            end
            StGrant: begin
                if (transfer) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (cur_last || burst_hit) begin
                        state_d    = StIdle;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_id_q == LastReq) ? '0 : grant_id_q + 1'b1;
                        // Last on the limit beat is a clean end of packet.
                        if (!cur_last) begin
                            burst_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_id_o  = grant_id_q;
    assign beat_cnt_o  = beat_cnt_q;
    assign burst_err_o = burst_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-written
// sequences for the burst limit and mid-packet reset.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int BW = 64;
    localparam int MB = 16;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid_i;
    logic [NR*BW-1:0] req_data_i;
    logic [NR-1:0]    req_last_i;
    logic [NR-1:0]    req_ready_o;
    logic             fifo_full_i;
    logic             fifo_wr_o;
    logic [BW-1:0]    fifo_data_o;
    logic [NR-1:0]    grant_o;
    logic [1:0]       grant_id_o;
    logic [4:0]       beat_cnt_o;
    logic             burst_err_o;

    fifo_wr_arbiter #(
        .NUM_REQ  (NR),
        .BITWIDTH (BW),
        .MAX_BURST(MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid_i),
        .req_data_i (req_data_i),
        .req_last_i (req_last_i),
        .req_ready_o(req_ready_o),
        .fifo_full_i(fifo_full_i),
        .fifo_wr_o  (fifo_wr_o),
        .fifo_data_o(fifo_data_o),
        .grant_o    (grant_o),
        .grant_id_o (grant_id_o),
        .beat_cnt_o (beat_cnt_o),
        .burst_err_o(burst_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [3:0] grant;
        logic [1:0] gid;
        logic       wr;
        logic [3:0] ready;
        logic [4:0] beat;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   tag    = 0;

    function automatic logic [BW-1:0] mk_data(input int k, input int t);
        return {8'hA0 + 8'(k), 24'(t), 32'h5A5A_0000 | 32'(k)};
    endfunction

    function automatic void add(input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic [3:0] g, input logic [1:0] id, input logic w,
                                input logic [3:0] r, input logic [4:0] b);
        vec_t x;
        x.valid = v; x.last = l; x.full = f; x.grant = g;
        x.gid = id; x.wr = w; x.ready = r; x.beat = b;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; outputs settle before the next rise.
    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic f);
        @(negedge clk);
        tag++;
        req_valid_i = v;
        req_last_i  = l;
        fifo_full_i = f;
        for (int k = 0; k < NR; k++) req_data_i[k*BW +: BW] = mk_data(k, tag);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] id,
                           input logic w, input logic [3:0] r, input logic [4:0] b,
                           input logic err);
        chk({name, ".grant"}, BW'(grant_o), BW'(g));
        chk({name, ".wr"}, BW'(fifo_wr_o), BW'(w));
        chk({name, ".ready"}, BW'(req_ready_o), BW'(r));
        chk({name, ".beat"}, BW'(beat_cnt_o), BW'(b));
        chk({name, ".err"}, BW'(burst_err_o), BW'(err));
        chk({name, ".data"}, fifo_data_o, (g != 4'b0) ? mk_data(int'(id), tag) : '0);
        if (g != 4'b0) chk({name, ".gid"}, BW'(grant_id_o), BW'(id));
    endtask

    initial begin
        // Requester 0, three beats, last on the third.
        add(4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0001, 4'b0000, 0, 4'b0001, 0, 1, 4'b0001, 0);
        add(4'b0001, 4'b0000, 0, 4'b0001, 0, 1, 4'b0001, 1);
        add(4'b0001, 4'b0001, 0, 4'b0001, 0, 1, 4'b0001, 2);
        add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        // All valid, single-beat packets; rr_ptr is 1 after the first packet.
        add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 4'b0010, 0);
        add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1111, 4'b1111, 0, 4'b0100, 2, 1, 4'b0100, 0);
        add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1111, 4'b1111, 0, 4'b1000, 3, 1, 4'b1000, 0);
        add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1111, 4'b1111, 0, 4'b0001, 0, 1, 4'b0001, 0);
        add(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 4'b0010, 0);
        add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        // Serve 2 to reach rr_ptr=3, then 3 and 1 contend: 3 first, scan wraps to 1.
        add(4'b0100, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0100, 4'b0100, 0, 4'b0100, 2, 1, 4'b0100, 0);
        add(4'b1010, 4'b1010, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1010, 4'b1010, 0, 4'b1000, 3, 1, 4'b1000, 0);
        add(4'b1010, 4'b1010, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b1010, 4'b1010, 0, 4'b0010, 1, 1, 4'b0010, 0);
        // Requester 2 with five cycles of FIFO full, a bubble, then the last beat.
        add(4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 4'b0100, 0);
        for (int i = 0; i < 5; i++) add(4'b1111, 4'b0000, 1, 4'b0100, 2, 0, 4'b0000, 1);
        add(4'b1011, 4'b0000, 0, 4'b0100, 2, 0, 4'b0100, 1);
        add(4'b0100, 4'b0100, 0, 4'b0100, 2, 1, 4'b0100, 1);
        add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);

        rst_n       = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        fifo_full_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.grant", BW'(grant_o), '0);
        chk("rst.gid", BW'(grant_id_o), '0);
        chk("rst.ready", BW'(req_ready_o), '0);
        chk("rst.wr", BW'(fifo_wr_o), '0);
        chk("rst.data", fifo_data_o, '0);
        chk("rst.beat", BW'(beat_cnt_o), '0);
        chk("rst.err", BW'(burst_err_o), '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].valid, vecs[i].last, vecs[i].full);
            chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].gid, vecs[i].wr,
                    vecs[i].ready, vecs[i].beat, 1'b0);
        end

        // rr_ptr=3: requester 0 sends 16 beats with last on the 16th -> clean release.
        cyc(4'b0001, 4'b0000, 0);
        chk_all("lm.idle", 4'b0000, 0, 0, 4'b0000, 0, 0);
        for (int b = 0; b < MB; b++) begin
            cyc(4'b0001, (b == MB - 1) ? 4'b0001 : 4'b0000, 0);
            chk_all($sformatf("lm.b%0d", b), 4'b0001, 0, 1, 4'b0001, 5'(b), 0);
        end
        cyc(4'b0000, 4'b0000, 0);
        chk_all("lm.end", 4'b0000, 0, 0, 4'b0000, 0, 0);

        // Requester 1 sends 20 beats with no last until the very end.
        cyc(4'b0010, 4'b0000, 0);
        chk_all("mb.idle", 4'b0000, 0, 0, 4'b0000, 0, 0);
        for (int b = 0; b < MB; b++) begin
            cyc(4'b0010, 4'b0000, 0);
            chk_all($sformatf("mb.b%0d", b), 4'b0010, 1, 1, 4'b0010, 5'(b), 0);
        end
        cyc(4'b0010, 4'b0000, 0);
        chk_all("mb.rel", 4'b0000, 0, 0, 4'b0000, 0, 1);
        for (int b = 0; b < 4; b++) begin
            cyc(4'b0010, (b == 3) ? 4'b0010 : 4'b0000, 0);
            chk_all($sformatf("mb.r%0d", b), 4'b0010, 1, 1, 4'b0010, 5'(b), 1);
        end
        cyc(4'b0000, 4'b0000, 0);
        chk_all("mb.end", 4'b0000, 0, 0, 4'b0000, 0, 1);

        // Requester 3 mid-packet, then asynchronous reset during its second beat.
        cyc(4'b1000, 4'b0000, 0);
        chk_all("rs.idle", 4'b0000, 0, 0, 4'b0000, 0, 1);
        cyc(4'b1000, 4'b0000, 0);
        chk_all("rs.b0", 4'b1000, 3, 1, 4'b1000, 0, 1);
        cyc(4'b1000, 4'b0000, 0);
        chk_all("rs.b1", 4'b1000, 3, 1, 4'b1000, 1, 1);
        rst_n       = 1'b0;
        req_valid_i = '0;
        #1;
        chk_all("rs.async", 4'b0000, 0, 0, 4'b0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1010, 4'b0000, 0);
        chk_all("rs.idle2", 4'b0000, 0, 0, 4'b0000, 0, 0);
        cyc(4'b1010, 4'b0000, 0);
        chk_all("rs.regrant", 4'b0010, 1, 1, 4'b0010, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
